// File: rtl/cache_pkg.sv
// cache_pkg: shared constants, state encoding and tag-width helper for the 4-line cache.
package cache_pkg;
  localparam int INDEX_W = 2;
  localparam int LINES = 1 << INDEX_W;
  typedef enum logic [1:0] {IDLE, CHECK, FILL, RESP} state_e;
  function automatic int tag_w(input int addr_w);
    return addr_w - INDEX_W;
  endfunction
endpackage

// File: rtl/cache_valid_array.sv
// cache_valid_array: per-line valid bits with async clear, single-line set and clear-all.
module cache_valid_array
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_i,
  input  logic [INDEX_W-1:0] set_idx_i,
  input  logic               clr_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               valid_o
);
  logic [LINES-1:0] valid_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid_q <= '0;
    else if (clr_i) valid_q <= '0;
    else if (set_i) valid_q[set_idx_i] <= 1'b1;
  assign valid_o = valid_q[rd_idx_i];
endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: direct-mapped lookup with request/ack fill from backing memory.
module cache_fill_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int INDEX_W = cache_pkg::INDEX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              inv,
  output logic              busy,
  output logic              cpu_ready,
  output logic              cpu_hit,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  import cache_pkg::*;
  localparam int TAG_W = tag_w(ADDR_W);
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              hit_q, ready_q, mem_req_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               valid, hit, fill, clr;
  assign idx  = addr_q[INDEX_W-1:0];
  assign tag  = addr_q[ADDR_W-1:INDEX_W];
  assign hit  = valid && tag_q[idx] == tag;
  assign fill = state_q == FILL && mem_ack;
  assign clr  = state_q == IDLE && inv;
  cache_valid_array u_valid (
    .clk      (clk),
    .rst_n    (reset),
    .set_i    (fill),
    .set_idx_i(idx),
    .clr_i    (clr),
    .rd_idx_i (idx),
    .valid_o  (valid)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
      ready_q   <= 1'b0;
      mem_req_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!inv && cpu_req) begin
          addr_q  <= cpu_addr;
          state_q <= CHECK;
        end
        CHECK: if (hit) begin
          rdata_q <= data_q[idx];
          hit_q   <= 1'b1;
          ready_q <= 1'b1;
          state_q <= RESP;
        end else begin
          mem_req_q <= 1'b1;
          state_q   <= FILL;
        end
        FILL: if (mem_ack) begin
          mem_req_q <= 1'b0;
          rdata_q   <= mem_rdata;
          hit_q     <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= RESP;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  // Tag/data contents are meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clk)
    if (fill) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= mem_rdata;
    end
  assign busy      = state_q != IDLE;
  assign cpu_ready = ready_q;
  assign cpu_hit   = hit_q;
  assign cpu_rdata = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = addr_q;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed steps with a response scoreboard checked on every cpu_ready.
module tb_cache_fill_ctrl;
  logic       clk = 1'b0;
  logic       reset, cpu_req, inv, mem_ack;
  logic [7:0] cpu_addr, mem_rdata;
  logic       busy, cpu_ready, cpu_hit, mem_req;
  logic [7:0] cpu_rdata, mem_addr;
  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  cache_fill_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .inv      (inv),
    .busy     (busy),
    .cpu_ready(cpu_ready),
    .cpu_hit  (cpu_hit),
    .cpu_rdata(cpu_rdata),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (cpu_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_ready", {31'b0, cpu_ready}, 32'd0);
      else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("resp_hit", {31'b0, cpu_hit}, {31'b0, e[8]});
        chk("resp_data", {24'b0, cpu_rdata}, {24'b0, e[7:0]});
      end
    end

  // One request from acceptance through response, with cycle-exact handshake checks.
  task automatic req(input logic [7:0] a, input bit eh, input logic [7:0] d, input int w,
                     input bit inv_first = 1'b0, input bit inv_fill = 1'b0);
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = a;
    inv = inv_first;
    exp_q.push_back({eh, d});
    if (inv_first) begin
      @(negedge clk);
      inv = 1'b0;
      chk("inv_blocks_accept", {31'b0, busy}, 32'd0);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    chk("check_busy", {31'b0, busy}, 32'd1);
    chk("check_no_memreq", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    if (eh) begin
      chk("hit_ready", {31'b0, cpu_ready}, 32'd1);
      chk("hit_no_memreq", {31'b0, mem_req}, 32'd0);
    end else begin
      chk("fill_memreq", {31'b0, mem_req}, 32'd1);
      chk("fill_memaddr", {24'b0, mem_addr}, {24'b0, a});
      chk("fill_no_ready", {31'b0, cpu_ready}, 32'd0);
      if (inv_fill) inv = 1'b1;
      for (int i = 0; i < w; i++) begin
        @(negedge clk);
        inv = 1'b0;
        chk("fill_memreq_held", {31'b0, mem_req}, 32'd1);
        chk("fill_memaddr_held", {24'b0, mem_addr}, {24'b0, a});
      end
      mem_ack = 1'b1;
      mem_rdata = d;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = 8'h00;
      chk("fill_ready", {31'b0, cpu_ready}, 32'd1);
      chk("fill_memreq_drop", {31'b0, mem_req}, 32'd0);
    end
    @(negedge clk);
    chk("ready_one_cycle", {31'b0, cpu_ready}, 32'd0);
    chk("back_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n_ready, first, second;
    bit saw_memreq;
    reset = 1'b1; cpu_req = 1'b0; inv = 1'b0; mem_ack = 1'b0;
    cpu_addr = 8'h00; mem_rdata = 8'h00;
    #1 reset = 1'b0;
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, cpu_ready}, 32'd0);
    chk("rst_hit", {31'b0, cpu_hit}, 32'd0);
    chk("rst_memreq", {31'b0, mem_req}, 32'd0);
    chk("rst_rdata", {24'b0, cpu_rdata}, 32'd0);
    chk("rst_memaddr", {24'b0, mem_addr}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    // cold miss, hit, then conflicting tag on the same index
    req(8'h25, 1'b0, 8'hA7, 3);
    req(8'h25, 1'b1, 8'hA7, 0);
    req(8'h45, 1'b0, 8'h3C, 1);
    req(8'h25, 1'b0, 8'hA7, 0);
    // invalidate pulse in idle
    @(negedge clk);
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    req(8'h25, 1'b0, 8'hA7, 0);
    req(8'h45, 1'b0, 8'h3C, 0);
    // inv together with a held request: invalidate wins, request taken next edge
    req(8'h45, 1'b0, 8'h3C, 2, 1'b1);
    // inv during fill is ignored
    req(8'h13, 1'b0, 8'h5A, 2, 1'b0, 1'b1);
    req(8'h13, 1'b1, 8'h5A, 0);
    // reset in the middle of a fill
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = 8'h8A;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("midfill_memreq", {31'b0, mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_memreq_drop", {31'b0, mem_req}, 32'd0);
    chk("async_busy_drop", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 8'hEE;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_busy", {31'b0, busy}, 32'd0);
    chk("late_ack_ready", {31'b0, cpu_ready}, 32'd0);
    req(8'h8A, 1'b0, 8'h66, 0);
    req(8'h13, 1'b0, 8'h5A, 0);
    // held request: two back-to-back hits
    req(8'h25, 1'b0, 8'hA7, 0);
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = 8'h25;
    exp_q.push_back({1'b1, 8'hA7});
    exp_q.push_back({1'b1, 8'hA7});
    n_ready = 0; first = -1; second = -1; saw_memreq = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 4) cpu_req = 1'b0;
      if (mem_req) saw_memreq = 1'b1;
      if (cpu_ready) begin
        n_ready++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk("held_ready_count", n_ready, 32'd2);
    chk("held_first_ready", first, 32'd2);
    chk("held_spacing", second - first, 32'd3);
    chk("held_no_memreq", {31'b0, saw_memreq}, 32'd0);
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Lookup-and-fill controller for the 4-line direct-mapped cache. It owns the tag, data and valid state and answers CPU read requests. On a hit it returns the stored word. On a miss it runs a request/acknowledge read to backing memory, writes the returned word into the line, sets the line's valid bit, and returns the word. It sits between the CPU read port and the memory read port and is the sole writer of the valid array.

## Interface
- `ADDR_W`, default 8: CPU/memory address width.
- `DATA_W`, default 8: word width; one word per line.
- `INDEX_W`, default 2: line index width; fixed at 2 for 4 lines.
- `clk` input, 1: clock; all state updates on the rising edge.
- `reset` input, 1: asynchronous, active-low; 0 resets immediately.
- `cpu_req` input, 1: read request (level).
- `cpu_addr` input, ADDR_W: read address; sampled when the request is accepted.
- `inv` input, 1: invalidate all lines.
- `busy` output, 1: controller not idle.
- `cpu_ready` output, 1: one-cycle response strobe.
- `cpu_hit` output, 1: 1 = hit, 0 = served by fill; meaningful only with `cpu_ready`.
- `cpu_rdata` output, DATA_W: response word.
- `mem_req` output, 1: memory read request.
- `mem_addr` output, ADDR_W: memory read address.
- `mem_ack` input, 1: memory data valid.
- `mem_rdata` input, DATA_W: memory word.

## Operation
- Address split:
  - index = `cpu_addr[INDEX_W-1:0]`
  - tag = `cpu_addr[ADDR_W-1:INDEX_W]`, 6 bits at defaults.
- States: IDLE, CHECK, FILL, RESP.
- IDLE:
  - If `inv` is 1: clear all 4 valid bits and do not accept a request this cycle.
  - Else if `cpu_req` is 1: latch the address and go to CHECK.
- CHECK:
  - If the line's valid bit is 1 and its tag equals the latched tag: load `cpu_rdata` from the data array, set `cpu_hit` = 1, go to RESP.
  - Otherwise go to FILL.
- FILL:
  - `mem_req` = 1 and `mem_addr` = latched address, held stable until `mem_ack`.
  - On `mem_ack`: write `mem_rdata` to the data array, write the latched tag, set the valid bit, load `cpu_rdata` = `mem_rdata`, set `cpu_hit` = 0, go to RESP.
- RESP: `cpu_ready` = 1 for exactly one cycle, then IDLE.
- `busy` = (state != IDLE).
- Ignored inputs:
  - `inv` outside IDLE is ignored; the requester holds it until `busy` is 0.
  - `mem_ack` outside FILL is ignored.
  - `cpu_req` outside IDLE is ignored.
- `cpu_rdata` and `cpu_hit` hold their last values between responses.
- Reset values:
  - Controller: state IDLE; `busy`, `cpu_ready`, `cpu_hit`, `mem_req` = 0; `cpu_rdata`, `mem_addr` = 0.
  - Valid bits: all 0.
  - Tag and data arrays: not reset.
- Reset during FILL:
  - `mem_req` drops asynchronously and the fill is abandoned.
  - The line stays invalid.
  - A late `mem_ack` is ignored.

## Timing
- Request accepted at edge N, in IDLE with `cpu_req` = 1 and `inv` = 0.
- Hit: CHECK in cycle N+1; `cpu_ready` high in cycle N+2.
- Miss:
  - `mem_req` high from cycle N+2.
  - `mem_ack` sampled at edge M ⇒ `cpu_ready` high in cycle M+1.
  - Minimum miss latency is 3 cycles, with `mem_ack` in the first FILL cycle.
- `mem_req` deasserts the cycle after `mem_ack` is sampled; the handshake has no combinational path from `mem_ack` to `mem_req`.
- If `cpu_req` is still 1 when the controller returns to IDLE, the next request is accepted at that edge. Back-to-back hits therefore occur every 3 cycles.
- `inv` takes effect at the edge it is sampled. A CHECK in the following cycle sees the cleared bits.

## Structure
- Package `cache_pkg` holds:
  - the state enum (IDLE/CHECK/FILL/RESP);
  - the `INDEX_W` and line-count constants;
  - the tag-width expression.
- Sub-module `cache_valid_array`:
  - 4 valid bits;
  - asynchronous active-low clear;
  - synchronous set of one line;
  - synchronous clear-all on `inv`;
  - combinational read by index.
- Tag and data arrays are plain registers inside the controller.

## Test plan
- **Cold miss:** release reset, request 0x25.
  - `mem_req` = 1 with `mem_addr` = 0x25 two cycles after acceptance.
  - Ack with 0xA7 after 3 cycles ⇒ `cpu_ready` next cycle, `cpu_rdata` = 0xA7, `cpu_hit` = 0.
- **Hit:** request 0x25 again.
  - `cpu_ready` 2 cycles after acceptance, `cpu_hit` = 1, `cpu_rdata` = 0xA7.
  - `mem_req` never asserts.
- **Conflict:** request 0x45 (index 1, different tag) ⇒ miss, fill 0x3C, `cpu_hit` = 0. Then request 0x25 ⇒ miss again.
- **Invalidate:**
  - `inv` pulse in IDLE, then request 0x45 ⇒ miss.
  - `inv` and `cpu_req` both high one cycle, with `cpu_req` held ⇒ invalidate first, request accepted the next edge.
  - `inv` during FILL ⇒ ignored, line filled and valid.
- **Reset mid-fill:** assert `reset` (0) while `mem_req` = 1.
  - `mem_req` = 0 with no clock edge.
  - `mem_ack` pulse after release ignored.
  - A request to the same address misses.
- **Held request:** `cpu_req` held high across two hits to 0x25 ⇒ `cpu_ready` pulses exactly 3 cycles apart, each one cycle wide.
